// File: rtl/ldst_agu_pipe.sv
// Load/store address-generation pipe: S1 forms addr/be/wdata and checks alignment,
// S2 holds the request presented to the dcache/store-buffer over valid/ready.
module ldst_agu_pipe #(
    parameter int unsigned DATA_LEN    = 32,
    parameter int unsigned TAG_W       = 6,
    parameter int unsigned SPECTAG_LEN = 5,
    parameter int unsigned OP_W        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   iss_valid,
    output logic                   iss_ready,
    input  logic [OP_W-1:0]        iss_op,
    input  logic [DATA_LEN-1:0]    iss_base,
    input  logic [DATA_LEN-1:0]    iss_imm,
    input  logic [DATA_LEN-1:0]    iss_sdata,
    input  logic [TAG_W-1:0]       iss_dest,
    input  logic                   iss_dstval,
    input  logic [SPECTAG_LEN-1:0] iss_spectag,
    input  logic                   iss_specbit,
    input  logic                   prmiss,
    input  logic                   prsuccess,
    input  logic [SPECTAG_LEN-1:0] prtag,
    input  logic [SPECTAG_LEN-1:0] specfixtag,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_we,
    output logic [DATA_LEN-1:0]    mem_addr,
    output logic [3:0]             mem_be,
    output logic [DATA_LEN-1:0]    mem_wdata,
    output logic [OP_W-1:0]        mem_op,
    output logic [TAG_W-1:0]       mem_dest,
    output logic                   mem_dstval,
    output logic [SPECTAG_LEN-1:0] mem_spectag,
    output logic                   mem_specbit,
    output logic                   exc_valid,
    output logic [TAG_W-1:0]       exc_dest
);

    // S1 state
    logic                   s1_valid_q, s1_valid_d;
    logic [OP_W-1:0]        s1_op_q, s1_op_d;
    logic [DATA_LEN-1:0]    s1_base_q, s1_base_d;
    logic [DATA_LEN-1:0]    s1_imm_q, s1_imm_d;
    logic [DATA_LEN-1:0]    s1_sdata_q, s1_sdata_d;
    logic [TAG_W-1:0]       s1_dest_q, s1_dest_d;
    logic                   s1_dstval_q, s1_dstval_d;
    logic [SPECTAG_LEN-1:0] s1_spectag_q, s1_spectag_d;
    logic                   s1_specbit_q, s1_specbit_d;

    // S2 state
    logic                   s2_valid_q, s2_valid_d;
    logic                   s2_we_q, s2_we_d;
    logic [DATA_LEN-1:0]    s2_addr_q, s2_addr_d;
    logic [3:0]             s2_be_q, s2_be_d;
    logic [DATA_LEN-1:0]    s2_wdata_q, s2_wdata_d;
    logic [OP_W-1:0]        s2_op_q, s2_op_d;
    logic [TAG_W-1:0]       s2_dest_q, s2_dest_d;
    logic                   s2_dstval_q, s2_dstval_d;
    logic [SPECTAG_LEN-1:0] s2_spectag_q, s2_spectag_d;
    logic                   s2_specbit_q, s2_specbit_d;

    logic                   exc_valid_q, exc_valid_d;
    logic [TAG_W-1:0]       exc_dest_q, exc_dest_d;

    logic                   resolve;
    logic                   kill_iss, kill_s1, kill_s2;
    logic                   iss_specbit_upd, s1_specbit_upd, s2_specbit_upd;
    logic [DATA_LEN-1:0]    s1_addr;
    logic [3:0]             s1_be;
    logic [DATA_LEN-1:0]    s1_wdata;
    logic                   s1_fault;
    logic                   s1_adv, s2_adv;

    // prmiss takes priority over a same-cycle prsuccess
    assign resolve  = prsuccess && !prmiss;
    assign kill_iss = prmiss && iss_specbit && |(iss_spectag & specfixtag);
    assign kill_s1  = prmiss && s1_specbit_q && |(s1_spectag_q & specfixtag);
    assign kill_s2  = prmiss && s2_specbit_q && |(s2_spectag_q & specfixtag);

    assign iss_specbit_upd = iss_specbit && !(resolve && (iss_spectag == prtag));
    assign s1_specbit_upd  = s1_specbit_q && !(resolve && (s1_spectag_q == prtag));
    assign s2_specbit_upd  = s2_specbit_q && !(resolve && (s2_spectag_q == prtag));

    assign s1_addr = s1_base_q + s1_imm_q;

    always_comb begin
        s1_be    = 4'b0000;
        s1_wdata = s1_sdata_q;
        s1_fault = 1'b0;
        unique case (s1_op_q[1:0])
            2'b00: begin
                s1_be    = 4'b0001 << s1_addr[1:0];
                s1_wdata = {(DATA_LEN/8){s1_sdata_q[7:0]}};
            end
            2'b01: begin
                s1_be    = 4'b0011 << s1_addr[1:0];
                s1_wdata = {(DATA_LEN/16){s1_sdata_q[15:0]}};
                s1_fault = s1_addr[0];
            end
            2'b10: begin
                s1_be    = 4'b1111;
                s1_fault = |s1_addr[1:0];
            end
            default: s1_fault = 1'b1;
        endcase
    end

    // A faulting entry retires from S1 straight into the exception pulse, never waiting on S2
    assign s2_adv    = !s2_valid_q || mem_req_ready;
    assign s1_adv    = s1_valid_q && (s1_fault || s2_adv);
    assign iss_ready = !s1_valid_q || s1_adv;

    always_comb begin
        s1_valid_d   = s1_valid_q && !kill_s1;
        s1_op_d      = s1_op_q;
        s1_base_d    = s1_base_q;
        s1_imm_d     = s1_imm_q;
        s1_sdata_d   = s1_sdata_q;
        s1_dest_d    = s1_dest_q;
        s1_dstval_d  = s1_dstval_q;
        s1_spectag_d = s1_spectag_q;
        s1_specbit_d = s1_specbit_upd;
        if (iss_ready) begin
            s1_valid_d = iss_valid && !kill_iss;
            if (iss_valid) begin
                s1_op_d      = iss_op;
                s1_base_d    = iss_base;
                s1_imm_d     = iss_imm;
                s1_sdata_d   = iss_sdata;
                s1_dest_d    = iss_dest;
                s1_dstval_d  = iss_dstval;
                s1_spectag_d = iss_spectag;
                s1_specbit_d = iss_specbit_upd;
            end
        end
    end

    always_comb begin
        s2_valid_d   = s2_valid_q && !kill_s2;
        s2_we_d      = s2_we_q;
        s2_addr_d    = s2_addr_q;
        s2_be_d      = s2_be_q;
        s2_wdata_d   = s2_wdata_q;
        s2_op_d      = s2_op_q;
        s2_dest_d    = s2_dest_q;
        s2_dstval_d  = s2_dstval_q;
        s2_spectag_d = s2_spectag_q;
        s2_specbit_d = s2_specbit_upd;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q && !s1_fault && !kill_s1;
            if (s1_valid_q && !s1_fault) begin
                s2_we_d      = s1_op_q[3];
                s2_addr_d    = s1_addr;
                s2_be_d      = s1_be;
                s2_wdata_d   = s1_wdata;
                s2_op_d      = s1_op_q;
                s2_dest_d    = s1_dest_q;
                s2_dstval_d  = s1_dstval_q;
                s2_spectag_d = s1_spectag_q;
                s2_specbit_d = s1_specbit_upd;
            end
        end
    end

    always_comb begin
        exc_valid_d = s1_valid_q && s1_fault && !kill_s1;
        exc_dest_d  = exc_valid_d ? s1_dest_q : exc_dest_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= '0;
            s1_base_q    <= '0;
            s1_imm_q     <= '0;
            s1_sdata_q   <= '0;
            s1_dest_q    <= '0;
            s1_dstval_q  <= 1'b0;
            s1_spectag_q <= '0;
            s1_specbit_q <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_we_q      <= 1'b0;
            s2_addr_q    <= '0;
            s2_be_q      <= '0;
            s2_wdata_q   <= '0;
            s2_op_q      <= '0;
            s2_dest_q    <= '0;
            s2_dstval_q  <= 1'b0;
            s2_spectag_q <= '0;
            s2_specbit_q <= 1'b0;
            exc_valid_q  <= 1'b0;
            exc_dest_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_base_q    <= s1_base_d;
            s1_imm_q     <= s1_imm_d;
            s1_sdata_q   <= s1_sdata_d;
            s1_dest_q    <= s1_dest_d;
            s1_dstval_q  <= s1_dstval_d;
            s1_spectag_q <= s1_spectag_d;
            s1_specbit_q <= s1_specbit_d;
            s2_valid_q   <= s2_valid_d;
            s2_we_q      <= s2_we_d;
            s2_addr_q    <= s2_addr_d;
            s2_be_q      <= s2_be_d;
            s2_wdata_q   <= s2_wdata_d;
            s2_op_q      <= s2_op_d;
            s2_dest_q    <= s2_dest_d;
            s2_dstval_q  <= s2_dstval_d;
            s2_spectag_q <= s2_spectag_d;
            s2_specbit_q <= s2_specbit_d;
            exc_valid_q  <= exc_valid_d;
            exc_dest_q   <= exc_dest_d;
        end
    end

    assign mem_req_valid = s2_valid_q && !kill_s2;
    assign mem_we        = s2_we_q;
    assign mem_addr      = s2_addr_q;
    assign mem_be        = s2_be_q;
    assign mem_wdata     = s2_wdata_q;
    assign mem_op        = s2_op_q;
    assign mem_dest      = s2_dest_q;
    assign mem_dstval    = s2_dstval_q;
    assign mem_spectag   = s2_spectag_q;
    assign mem_specbit   = s2_specbit_q;
    assign exc_valid     = exc_valid_q;
    assign exc_dest      = exc_dest_q;

endmodule

// File: tb/tb_ldst_agu_pipe.sv
// Bench for ldst_agu_pipe: directed scenarios plus a randomized run scored against an
// in-order byte-level model of address, byte-enable and store-data forming.
module tb_ldst_agu_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iss_valid = 1'b0;
    logic        iss_ready;
    logic [3:0]  iss_op = '0;
    logic [31:0] iss_base = '0;
    logic [31:0] iss_imm = '0;
    logic [31:0] iss_sdata = '0;
    logic [5:0]  iss_dest = '0;
    logic        iss_dstval = 1'b0;
    logic [4:0]  iss_spectag = '0;
    logic        iss_specbit = 1'b0;
    logic        prmiss = 1'b0;
    logic        prsuccess = 1'b0;
    logic [4:0]  prtag = '0;
    logic [4:0]  specfixtag = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_op;
    logic [5:0]  mem_dest;
    logic        mem_dstval;
    logic [4:0]  mem_spectag;
    logic        mem_specbit;
    logic        exc_valid;
    logic [5:0]  exc_dest;

    ldst_agu_pipe dut (
        .clk           (clk),
        .rst           (rst),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_op        (iss_op),
        .iss_base      (iss_base),
        .iss_imm       (iss_imm),
        .iss_sdata     (iss_sdata),
        .iss_dest      (iss_dest),
        .iss_dstval    (iss_dstval),
        .iss_spectag   (iss_spectag),
        .iss_specbit   (iss_specbit),
        .prmiss        (prmiss),
        .prsuccess     (prsuccess),
        .prtag         (prtag),
        .specfixtag    (specfixtag),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_op        (mem_op),
        .mem_dest      (mem_dest),
        .mem_dstval    (mem_dstval),
        .mem_spectag   (mem_spectag),
        .mem_specbit   (mem_specbit),
        .exc_valid     (exc_valid),
        .exc_dest      (exc_dest)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  op;
        logic [5:0]  dest;
        logic        dstval;
    } req_t;

    req_t       req_q[$];
    logic [5:0] exc_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_issue(input logic [3:0] op, input logic [31:0] base,
                               input logic [31:0] imm, input logic [31:0] sdata,
                               input logic [5:0] dest, input logic specbit,
                               input logic [4:0] spectag);
        iss_valid   = 1'b1;
        iss_op      = op;
        iss_base    = base;
        iss_imm     = imm;
        iss_sdata   = sdata;
        iss_dest    = dest;
        iss_dstval  = 1'b1;
        iss_specbit = specbit;
        iss_spectag = spectag;
    endtask

    // Reference: byte-lane view of one accepted ld/st, pushed to the request or fault queue
    task automatic model_issue(input logic [3:0] op, input logic [31:0] base,
                               input logic [31:0] imm, input logic [31:0] sdata,
                               input logic [5:0] dest, input logic dstval);
        logic [31:0] a;
        int          nb;
        int          be_i;
        req_t        r;
        a = base + imm;
        if (op[1:0] == 2'b11) begin
            exc_q.push_back(dest);
            return;
        end
        nb = 1 << op[1:0];
        if ((a % nb) != 0) begin
            exc_q.push_back(dest);
            return;
        end
        be_i = ((1 << nb) - 1) << (a % 4);
        r.we     = op[3];
        r.addr   = a;
        r.be     = be_i[3:0];
        for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = sdata[8*(i % nb) +: 8];
        r.op     = op;
        r.dest   = dest;
        r.dstval = dstval;
        req_q.push_back(r);
    endtask

    initial begin
        logic [31:0] rv;
        logic        prev_stall;
        req_t        prev;
        req_t        exp_r;

        // Reset state
        tick();
        tick();
        settle();
        check_eq("rst_mem_req_valid", mem_req_valid, 0);
        check_eq("rst_iss_ready", iss_ready, 1);
        check_eq("rst_exc_valid", exc_valid, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        rst = 1'b1;
        tick();

        // Word load: 2-cycle latency
        mem_req_ready = 1'b1;
        drive_issue(4'b0010, 32'h1000, 32'h10, 32'h0, 6'h01, 1'b0, 5'b0);
        settle();
        check_eq("w_iss_ready", iss_ready, 1);
        tick();
        iss_valid = 1'b0;
        settle();
        check_eq("w_not_yet", mem_req_valid, 0);
        tick();
        settle();
        check_eq("w_valid", mem_req_valid, 1);
        check_eq("w_addr", mem_addr, 32'h1010);
        check_eq("w_be", mem_be, 4'hF);
        check_eq("w_we", mem_we, 0);
        tick();
        settle();
        check_eq("w_gone", mem_req_valid, 0);

        // Byte store at lane 3
        drive_issue(4'b1000, 32'h2003, 32'h0, 32'hA5, 6'h02, 1'b0, 5'b0);
        tick();
        iss_valid = 1'b0;
        tick();
        settle();
        check_eq("sb_valid", mem_req_valid, 1);
        check_eq("sb_we", mem_we, 1);
        check_eq("sb_be", mem_be, 4'b1000);
        check_eq("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        tick();

        // Misaligned half load faults
        drive_issue(4'b0001, 32'h3001, 32'h0, 32'h0, 6'h12, 1'b0, 5'b0);
        tick();
        iss_valid = 1'b0;
        settle();
        check_eq("mh_no_exc_early", exc_valid, 0);
        tick();
        settle();
        check_eq("mh_exc", exc_valid, 1);
        check_eq("mh_exc_dest", exc_dest, 6'h12);
        check_eq("mh_no_req", mem_req_valid, 0);
        tick();
        settle();
        check_eq("mh_exc_once", exc_valid, 0);
        check_eq("mh_no_req2", mem_req_valid, 0);

        // Backpressure: three back-to-back issues
        mem_req_ready = 1'b0;
        drive_issue(4'b0010, 32'h100, 32'h0, 32'h0, 6'h03, 1'b0, 5'b0);
        settle();
        check_eq("bp_rdy_a", iss_ready, 1);
        tick();
        drive_issue(4'b0010, 32'h104, 32'h0, 32'h0, 6'h04, 1'b0, 5'b0);
        settle();
        check_eq("bp_rdy_b", iss_ready, 1);
        tick();
        drive_issue(4'b0010, 32'h108, 32'h0, 32'h0, 6'h05, 1'b0, 5'b0);
        settle();
        check_eq("bp_rdy_c", iss_ready, 0);
        check_eq("bp_valid", mem_req_valid, 1);
        check_eq("bp_addr", mem_addr, 32'h100);
        tick();
        settle();
        check_eq("bp_rdy_c2", iss_ready, 0);
        check_eq("bp_addr_stable", mem_addr, 32'h100);
        check_eq("bp_dest_stable", mem_dest, 6'h03);
        mem_req_ready = 1'b1;
        settle();
        check_eq("bp_rdy_rel", iss_ready, 1);
        tick();
        iss_valid = 1'b0;
        settle();
        check_eq("bp_b_valid", mem_req_valid, 1);
        check_eq("bp_b_addr", mem_addr, 32'h104);
        tick();
        settle();
        check_eq("bp_c_valid", mem_req_valid, 1);
        check_eq("bp_c_addr", mem_addr, 32'h108);
        tick();
        settle();
        check_eq("bp_drained", mem_req_valid, 0);

        // Squash entries in S1 and S2
        mem_req_ready = 1'b0;
        drive_issue(4'b0010, 32'h200, 32'h0, 32'h0, 6'h06, 1'b1, 5'b00010);
        tick();
        drive_issue(4'b0010, 32'h204, 32'h0, 32'h0, 6'h07, 1'b1, 5'b00010);
        tick();
        iss_valid = 1'b0;
        settle();
        check_eq("sq_pre_valid", mem_req_valid, 1);
        prmiss     = 1'b1;
        specfixtag = 5'b00110;
        settle();
        check_eq("sq_drop_now", mem_req_valid, 0);
        tick();
        prmiss = 1'b0;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq("sq_no_req", mem_req_valid, 0);
            check_eq("sq_no_exc", exc_valid, 0);
            tick();
        end

        // Killed issue is handshaken and dropped
        drive_issue(4'b0010, 32'h220, 32'h0, 32'h0, 6'h08, 1'b1, 5'b00100);
        prmiss     = 1'b1;
        specfixtag = 5'b00100;
        settle();
        check_eq("ki_ready", iss_ready, 1);
        tick();
        prmiss    = 1'b0;
        iss_valid = 1'b0;
        tick();
        settle();
        check_eq("ki_no_req", mem_req_valid, 0);
        tick();

        // Resolve clears specbit; later prmiss leaves the entry alone
        mem_req_ready = 1'b0;
        drive_issue(4'b0010, 32'h300, 32'h0, 32'h0, 6'h09, 1'b1, 5'b00001);
        tick();
        iss_valid = 1'b0;
        tick();
        settle();
        check_eq("rs_specbit_pre", mem_specbit, 1);
        prsuccess = 1'b1;
        prtag     = 5'b00001;
        tick();
        prsuccess = 1'b0;
        settle();
        check_eq("rs_specbit_clr", mem_specbit, 0);
        prmiss     = 1'b1;
        specfixtag = 5'b00001;
        settle();
        check_eq("rs_survive", mem_req_valid, 1);
        tick();
        prmiss = 1'b0;
        settle();
        check_eq("rs_survive2", mem_req_valid, 1);
        check_eq("rs_addr", mem_addr, 32'h300);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;

        // prmiss beats a same-cycle prsuccess
        drive_issue(4'b0010, 32'h400, 32'h0, 32'h0, 6'h0A, 1'b1, 5'b00001);
        tick();
        iss_valid = 1'b0;
        tick();
        prmiss     = 1'b1;
        prsuccess  = 1'b1;
        specfixtag = 5'b00001;
        prtag      = 5'b00001;
        settle();
        check_eq("pp_killed_now", mem_req_valid, 0);
        tick();
        prmiss    = 1'b0;
        prsuccess = 1'b0;
        settle();
        check_eq("pp_killed", mem_req_valid, 0);

        // Reset mid-handshake withdraws the request
        drive_issue(4'b0010, 32'h500, 32'h0, 32'h0, 6'h0B, 1'b0, 5'b0);
        tick();
        iss_valid = 1'b0;
        tick();
        settle();
        check_eq("rm_valid", mem_req_valid, 1);
        rst = 1'b0;
        #1;
        check_eq("rm_dropped", mem_req_valid, 0);
        check_eq("rm_addr", mem_addr, 0);
        check_eq("rm_ready", iss_ready, 1);
        tick();
        rst = 1'b1;
        tick();

        // Randomized run against the model (no speculation)
        prev_stall = 1'b0;
        prev       = '0;
        for (int c = 0; c < 1500; c++) begin
            rv          = $urandom;
            iss_valid   = ($urandom_range(0, 9) < 7);
            iss_op      = rv[3:0];
            iss_base    = $urandom;
            iss_imm     = {{26{rv[9]}}, rv[9:4]};
            iss_sdata   = $urandom;
            iss_dest    = rv[15:10];
            iss_dstval  = rv[16];
            iss_specbit = 1'b0;
            mem_req_ready = ($urandom_range(0, 9) < 6);
            settle();
            if (prev_stall) begin
                check_eq("st_valid", mem_req_valid, 1);
                check_eq("st_addr", mem_addr, prev.addr);
                check_eq("st_wdata", mem_wdata, prev.wdata);
                check_eq("st_misc", {mem_we, mem_be, mem_op, mem_dest, mem_dstval},
                         {prev.we, prev.be, prev.op, prev.dest, prev.dstval});
            end
            if (iss_valid && iss_ready)
                model_issue(iss_op, iss_base, iss_imm, iss_sdata, iss_dest, iss_dstval);
            if (mem_req_valid && mem_req_ready) begin
                check_eq("rnd_req_expected", (req_q.size() != 0), 1);
                if (req_q.size() != 0) begin
                    exp_r = req_q.pop_front();
                    check_eq("rnd_addr", mem_addr, exp_r.addr);
                    check_eq("rnd_be", mem_be, exp_r.be);
                    check_eq("rnd_wdata", mem_wdata, exp_r.wdata);
                    check_eq("rnd_misc", {mem_we, mem_op, mem_dest, mem_dstval},
                             {exp_r.we, exp_r.op, exp_r.dest, exp_r.dstval});
                end
            end
            if (exc_valid) begin
                check_eq("rnd_exc_expected", (exc_q.size() != 0), 1);
                if (exc_q.size() != 0) check_eq("rnd_exc_dest", exc_dest, exc_q.pop_front());
            end
            prev_stall = mem_req_valid && !mem_req_ready;
            prev       = '{we: mem_we, addr: mem_addr, be: mem_be, wdata: mem_wdata,
                           op: mem_op, dest: mem_dest, dstval: mem_dstval};
            tick();
        end

        // Drain and confirm nothing is left behind
        iss_valid     = 1'b0;
        mem_req_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            settle();
            if (mem_req_valid && req_q.size() != 0) begin
                exp_r = req_q.pop_front();
                check_eq("dr_addr", mem_addr, exp_r.addr);
            end
            if (exc_valid && exc_q.size() != 0) check_eq("dr_exc_dest", exc_dest, exc_q.pop_front());
            tick();
        end
        check_eq("dr_req_q_empty", req_q.size(), 0);
        check_eq("dr_exc_q_empty", exc_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
